// File: rtl/sound_pkg.sv
// Shared types and defaults for the audio playback path.
// Holds the controller state encoding and sample-period helpers.
package sound_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int DIV_W_DEF  = 11;
    localparam int MIN_DIV    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSE,
        ST_DONE
    } play_state_t;

    // Shorter periods leave no room between address and data phases.
    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/sample_tick.sv
// Sample-period phase counter: counts 0..div-1 while enabled.
// tick marks the last phase of a period.
module sample_tick
    import sound_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic [DIV_W-1:0] cnt,
    output logic             tick
);

    logic last;

    assign last = (cnt == div - DIV_W'(1));
    assign tick = en && last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/playback_ctrl.sv
// Sample-ROM playback controller feeding the PWM stage.
// Steps through a latched address range at a fixed sample period.
module playback_ctrl
    import sound_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [DIV_W-1:0]  rate_div,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              aud_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    play_state_t state_q, state_d;

    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic              tick;
    logic              last_q;

    logic idle_like;
    logic active;
    logic range_ok;
    logic accept;
    logic reject;
    logic en;
    logic load;
    logic kill;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign active    = (state_q == ST_PLAY) || (state_q == ST_PAUSE);
    assign range_ok  = (start_addr <= end_addr);
    assign accept    = idle_like && start && !stop && range_ok;
    assign reject    = idle_like && start && !stop && !range_ok;
    // Counting resumes on the same edge that leaves PAUSE.
    assign en        = active && !pause && !stop;
    assign load      = en && (cnt == DIV_W'(1));
    assign kill      = stop && (state_q != ST_IDLE);

    sample_tick #(
        .DIV_W(DIV_W)
    ) u_tick (
        .clk (clk),
        .rstn(rstn),
        .en  (en),
        .clr (accept),
        .div (div_q),
        .cnt (cnt),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = accept ? ST_PLAY : ST_IDLE;
            end
            ST_PLAY: begin
                if (stop)
                    state_d = ST_IDLE;
                else if (pause)
                    state_d = ST_PAUSE;
                else if (tick && last_q)
                    state_d = ST_DONE;
            end
            ST_PAUSE: begin
                if (stop)
                    state_d = ST_IDLE;
                else if (!pause)
                    state_d = (tick && last_q) ? ST_DONE : ST_PLAY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        aud_en = active;
        busy   = active;
        done   = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_q      <= '0;
            end_q        <= '0;
            div_q        <= DIV_W'(MIN_DIV);
            rom_addr     <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            err          <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            sample_valid <= load;
            err          <= reject;
            if (accept) begin
                start_q  <= start_addr;
                end_q    <= end_addr;
                div_q    <= DIV_W'(clamp_div(32'(rate_div)));
                rom_addr <= start_addr;
                last_q   <= 1'b0;
            end else if (load) begin
                sample <= rom_data;
                if (rom_addr < end_q)
                    rom_addr <= rom_addr + ADDR_W'(1);
                else if (loop_en)
                    rom_addr <= start_q;
                else
                    last_q <= 1'b1;
            end
            if (kill)
                sample <= '0;
        end
    end

endmodule

// File: tb/tb_playback_ctrl.sv
// Scoreboard bench for playback_ctrl with a registered ROM model.
// Directed scenarios push expected strobes; a monitor pops and compares.
module tb_playback_ctrl;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int VW = 11;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic [VW-1:0] rate_div = '0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          aud_en;
    logic          busy;
    logic          done;
    logic          err;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    exp_t smp_q[$];
    int   done_q[$];
    int   err_q[$];

    playback_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .loop_en     (loop_en),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .rate_div    (rate_div),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sample      (sample),
        .sample_valid(sample_valid),
        .aud_en      (aud_en),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= 32'hA500_0000 | {16'h0, rom_addr};
    end

    function automatic logic [31:0] rom_val(input int a);
        logic [15:0] lo;
        lo = a[15:0];
        return 32'hA500_0000 | {16'h0, lo};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_sample"}, sample, 0);
        chk({tag, "_valid"}, sample_valid, 0);
        chk({tag, "_aud_en"}, aud_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic push_smp(input int c, input int a);
        exp_t e;
        e.cyc  = c;
        e.data = rom_val(a);
        smp_q.push_back(e);
    endtask

    task automatic play(input int s, input int e, input int d,
                        input logic lp, output int acc);
        start_addr = AW'(s);
        end_addr   = AW'(e);
        rate_div   = VW'(d);
        loop_en    = lp;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc   = cyc;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (sample_valid) begin
                if (smp_q.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    exp_t e;
                    e = smp_q.pop_front();
                    chk("sample_cycle", cyc, e.cyc);
                    chk("sample_data", sample, e.data);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                    chk("done_aud_en", aud_en, 0);
                end
            end
            if (err) begin
                if (err_q.size() == 0)
                    chk("unexpected_err", 1, 0);
                else
                    chk("err_cycle", cyc, err_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        #1 rstn = 1'b0;
        #1 chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        play(4, 6, 8, 1'b0, a);
        push_smp(a + 2, 4);
        push_smp(a + 10, 5);
        push_smp(a + 18, 6);
        done_q.push_back(a + 24);
        chk("s1_addr0", rom_addr, 4);
        chk("s1_aud_on", aud_en, 1);
        wait_to(a + 3);
        chk("s1_addr1", rom_addr, 5);
        wait_to(a + 11);
        chk("s1_addr2", rom_addr, 6);
        wait_to(a + 23);
        chk("s1_aud_pre_done", aud_en, 1);
        wait_to(a + 24);
        chk("s1_aud_done", aud_en, 0);
        chk("s1_busy_done", busy, 0);
        wait_to(a + 26);

        play(4, 6, 8, 1'b1, a);
        push_smp(a + 2, 4);
        push_smp(a + 10, 5);
        push_smp(a + 18, 6);
        push_smp(a + 26, 4);
        push_smp(a + 34, 5);
        wait_to(a + 36);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("s2_stop_busy", busy, 0);
        chk("s2_stop_aud", aud_en, 0);
        chk("s2_stop_sample", sample, 0);
        wait_to(a + 40);
        loop_en = 1'b0;

        play(4, 6, 8, 1'b0, a);
        push_smp(a + 2, 4);
        push_smp(a + 15, 5);
        push_smp(a + 23, 6);
        done_q.push_back(a + 29);
        wait_to(a + 3);
        pause = 1'b1;
        wait_to(a + 6);
        chk("s3_pause_addr_mid", rom_addr, 5);
        wait_to(a + 8);
        chk("s3_pause_addr", rom_addr, 5);
        chk("s3_pause_busy", busy, 1);
        chk("s3_pause_aud", aud_en, 1);
        pause = 1'b0;
        wait_to(a + 31);

        play(9, 2, 8, 1'b0, a);
        err_q.push_back(a);
        chk("s4_busy", busy, 0);
        chk("s4_aud", aud_en, 0);
        chk("s4_addr_kept", rom_addr, 6);
        @(negedge clk);
        chk("s4_still_idle", busy, 0);

        play(10, 12, 1, 1'b0, a);
        push_smp(a + 2, 10);
        push_smp(a + 5, 11);
        push_smp(a + 8, 12);
        done_q.push_back(a + 9);
        wait_to(a + 11);
        start_addr = AW'(0);
        end_addr   = AW'(3);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("s5_startstop_busy", busy, 0);
        chk("s5_startstop_aud", aud_en, 0);
        repeat (3) @(negedge clk);
        chk("s5_stays_idle", busy, 0);

        play(20, 22, 4, 1'b0, a);
        push_smp(a + 2, 20);
        wait_to(a + 4);
        #3 rstn = 1'b0;
        #1 chk_zero("midreset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        play(30, 30, 3, 1'b0, a);
        chk("s6_new_addr", rom_addr, 30);
        push_smp(a + 2, 30);
        done_q.push_back(a + 3);
        wait_to(a + 6);
        chk("s6_idle_end", busy, 0);

        chk("samples_drained", smp_q.size(), 0);
        chk("done_drained", done_q.size(), 0);
        chk("err_drained", err_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
